srec_load_controller: RTL

Sequences image loading from `srec_parser` into a single-port byte memory and arbitrates that memory between the loader stream and a host debug port. Holds the CPU in reset while the image loads, then releases it once the serial stream has been idle for a set time. Latches the first parser error or address-range fault and halts in an error state. Sits between `srec_parser` and the program memory in the UART boot path.

---
 rtl/srec_load_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/srec_load_controller.sv
// Boot-path loader: writes the parsed S-record image into program memory, arbitrates
// that memory with a host debug port, and releases the CPU once the serial line goes quiet.
module srec_load_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  char_ready,
  input  logic                  format_error,
  input  logic                  checksum_error,
  input  logic [7:0]            error_location,
  input  logic [31:0]           write_address,
  input  logic [7:0]            write_byte,
  input  logic                  write_enable,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_ack,
  output logic [7:0]            host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  cpu_reset_n,
  output logic [1:0]            load_state,
  output logic [1:0]            error_code,
  output logic [7:0]            error_where,
  output logic [31:0]           byte_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] idle_cnt_r;
  logic [1:0]       error_code_r, code_nx_s;
  logic [7:0]       error_where_r, where_nx_s;
  logic [31:0]      byte_count_r;
  logic             host_ack_r, cpu_reset_n_r;
  logic             active_s, in_range_s, loader_wr_s, range_err_s, host_grant_s;

  assign active_s     = (state_r == ST_IDLE) || (state_r == ST_LOADING);
  assign in_range_s   = (write_address >> ADDR_WIDTH) == 32'd0;
  assign loader_wr_s  = active_s && write_enable && in_range_s;
  assign range_err_s  = active_s && write_enable && !in_range_s;
  // Loader cannot be stalled, so the host only gets cycles the loader leaves free.
  assign host_grant_s = host_req && !loader_wr_s && !host_ack_r;

  // Next state and first-error capture
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = error_code_r;
    where_nx_s = error_where_r;
    case (state_r)
      ST_IDLE, ST_LOADING: begin
        if (format_error) begin
          state_nx_s = ST_ERROR;
          code_nx_s  = 2'd1;
          where_nx_s = error_location;
        end else if (checksum_error) begin
          state_nx_s = ST_ERROR;
          code_nx_s  = 2'd2;
          where_nx_s = error_location;
        end else if (range_err_s) begin
          state_nx_s = ST_ERROR;
          code_nx_s  = 2'd3;
          where_nx_s = 8'd0;
        end else if ((state_r == ST_IDLE) && loader_wr_s) begin
          state_nx_s = ST_LOADING;
        end else if ((state_r == ST_LOADING) && !char_ready && (idle_cnt_r == CNT_LAST)) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_RUN, ST_ERROR: state_nx_s = state_r;
      default:          state_nx_s = ST_IDLE;
    endcase
  end

  // Memory port mux: reset gate, then loader, then host
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (!reset_n) begin
      mem_en = 1'b0;
    end else if (loader_wr_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = write_address[ADDR_WIDTH-1:0];
      mem_wdata = write_byte;
    end else if (host_grant_s) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Serial-idle counter, only meaningful while LOADING
  always_ff @(posedge clock) begin
    if (!reset_n || (state_r != ST_LOADING) || char_ready) begin
      idle_cnt_r <= '0;
    end else if (idle_cnt_r != CNT_MAX) begin
      idle_cnt_r <= idle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control, status and handshake registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      error_code_r  <= 2'd0;
      error_where_r <= 8'd0;
      byte_count_r  <= 32'd0;
      host_ack_r    <= 1'b0;
      cpu_reset_n_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      error_code_r  <= code_nx_s;
      error_where_r <= where_nx_s;
      if (loader_wr_s) begin
        byte_count_r <= byte_count_r + 32'd1;
      end
      host_ack_r    <= host_grant_s;
      cpu_reset_n_r <= (state_nx_s == ST_RUN);
    end
  end

  assign host_ack    = host_ack_r;
  assign host_rdata  = mem_rdata;
  assign cpu_reset_n = cpu_reset_n_r;
  assign load_state  = state_r;
  assign error_code  = error_code_r;
  assign error_where = error_where_r;
  assign byte_count  = byte_count_r;

endmodule
